btn_conditioner: RTL and testbench

Parametrised multi-channel push-button conditioner sitting between the board buttons (BTNC/U/D/L/R) and the Pong game logic. For each channel it does three things: synchronises the raw asynchronous input, debounces it with a per-channel counter, and emits a clean level plus single-cycle press and release pulses. Channels can optionally auto-repeat presses while held, for paddle movement. It replaces the ad-hoc raw button wiring into `pong_top` and supports any channel count and any debounce or repeat timing.

---
 rtl/btn_conditioner.sv | 84 ++++++++
 tb/tb_btn_conditioner.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/btn_conditioner.sv
// btn_conditioner: per-channel synchroniser, debouncer, press/release pulse generator
// and optional auto-repeat for the board push-buttons.
module btn_conditioner #(
   parameter int               N_BTN        = 5,
   parameter int               DB_CYCLES    = 1_000_000,
   parameter int               REPEAT_DELAY = 50_000_000,
   parameter int               REPEAT_RATE  = 10_000_000,
   parameter logic [N_BTN-1:0] REPEAT_MASK  = '0
) (
   input  logic             CLK100MHZ,
   input  logic             reset,
   input  logic             enable,
   input  logic [N_BTN-1:0] btn_in,
   output logic [N_BTN-1:0] btn_level,
   output logic [N_BTN-1:0] btn_press,
   output logic [N_BTN-1:0] btn_release
);
   localparam int DBW     = $clog2(DB_CYCLES + 1);
   localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int RW      = $clog2(RPT_MAX + 1);
   localparam logic [DBW-1:0] DB_LAST = DBW'(DB_CYCLES - 1);
   localparam logic [RW-1:0]  RD_LAST = RW'(REPEAT_DELAY - 1);
   localparam logic [RW-1:0]  RR_LAST = RW'(REPEAT_RATE - 1);

   typedef enum logic [1:0] {IDLE, WAIT, RPT} rpt_state_e;

   for (genvar i = 0; i < N_BTN; i++) begin : g_ch
      logic           s1_q, s2_q, stable_q, stable_d;
      logic           press_q, press_d, release_q, release_d;
      logic           accept, rpt_fire;
      logic [DBW-1:0] db_cnt_q, db_cnt_d;
      logic [RW-1:0]  rpt_cnt_q, rpt_cnt_d;
      rpt_state_e     state_q, state_d;

      always_comb begin
         accept    = (s2_q != stable_q) && (db_cnt_q == DB_LAST);
         stable_d  = accept ? s2_q : stable_q;
         db_cnt_d  = (s2_q == stable_q || accept) ? '0 : db_cnt_q + 1'b1;
         state_d   = state_q;
         rpt_cnt_d = rpt_cnt_q + 1'b1;
         rpt_fire  = 1'b0;
         // Looking at stable_d lets a release on a repeat boundary suppress that repeat.
         if (!REPEAT_MASK[i] || !enable || !stable_d) begin
            state_d   = IDLE;
            rpt_cnt_d = '0;
         end else if (state_q == IDLE) begin
            rpt_cnt_d = '0;
            state_d   = accept ? WAIT : IDLE;
         end else if (rpt_cnt_q == ((state_q == WAIT) ? RD_LAST : RR_LAST)) begin
            rpt_fire  = 1'b1;
            rpt_cnt_d = '0;
            state_d   = RPT;
         end
         press_d   = enable && ((accept && s2_q) || rpt_fire);
         release_d = enable && accept && !s2_q;
      end

      always_ff @(posedge CLK100MHZ or posedge reset) begin
         if (reset) begin
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            stable_q  <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            db_cnt_q  <= '0;
            rpt_cnt_q <= '0;
            state_q   <= IDLE;
         end else begin
            s1_q      <= btn_in[i];
            s2_q      <= s1_q;
            stable_q  <= stable_d;
            press_q   <= press_d;
            release_q <= release_d;
            db_cnt_q  <= db_cnt_d;
            rpt_cnt_q <= rpt_cnt_d;
            state_q   <= state_d;
         end
      end

      assign btn_level[i]   = stable_q;
      assign btn_press[i]   = press_q;
      assign btn_release[i] = release_q;
   end
endmodule

// File: tb/tb_btn_conditioner.sv
// tb_btn_conditioner: table vectors, hand-written corner sequences and random
// stimulus checked against a window-based reference model.
module tb_btn_conditioner;
   localparam int N = 5, DB = 4, RD = 10, RR = 3;

   typedef struct {
      logic [4:0] b;
      logic       e;
      int         n;
      logic [4:0] l, p, r;
   } vec_t;

   logic       clk = 1'b0, rst = 1'b1, en = 1'b1;
   logic [4:0] bin = '0, lvl, prs, rel;
   logic [4:0] mask_v = 5'b00110;
   int         tests = 0, fails = 0;

   logic [DB+1:0] rh [N];
   logic [4:0]    m_lvl, m_prs, m_rel;
   bit            act [N];
   int            age [N];
   vec_t          tbl [$];

   btn_conditioner #(.N_BTN(N), .DB_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_RATE(RR),
                     .REPEAT_MASK(5'b00110)) dut (
      .CLK100MHZ(clk), .reset(rst), .enable(en), .btn_in(bin),
      .btn_level(lvl), .btn_press(prs), .btn_release(rel));

   always #5 clk = ~clk;

   task automatic check(string nm, logic [14:0] a, logic [14:0] e);
      tests++;
      if (a !== e) begin
         fails++;
         $display("FAIL %s: got %h expected %h (level,press,release)", nm, a, e);
      end
   endtask

   task automatic m_reset();
      for (int c = 0; c < N; c++) begin
         rh[c]  = '0;
         act[c] = 0;
         age[c] = 0;
      end
      m_lvl = '0;
      m_prs = '0;
      m_rel = '0;
   endtask

   // A level is accepted once the last DB synchronised samples all disagree with it.
   task automatic cycle();
      @(posedge clk);
      if (rst) m_reset();
      else for (int c = 0; c < N; c++) begin
         logic [DB-1:0] win;
         bit acc;
         rh[c] = {rh[c][DB:0], bin[c]};
         win = rh[c][DB+1:2];
         acc = m_lvl[c] ? (win == '0) : (&win);
         m_prs[c] = 1'b0;
         m_rel[c] = 1'b0;
         if (acc) begin
            m_lvl[c] = ~m_lvl[c];
            m_prs[c] = en & m_lvl[c];
            m_rel[c] = en & ~m_lvl[c];
         end
         if (!en || !m_lvl[c] || !mask_v[c]) act[c] = 0;
         else if (acc) begin
            act[c] = 1;
            age[c] = 0;
         end else if (act[c]) begin
            age[c]++;
            if (age[c] >= RD && (age[c] - RD) % RR == 0) m_prs[c] = 1'b1;
         end
      end
      #1;
      check("model", {lvl, prs, rel}, {m_lvl, m_prs, m_rel});
   endtask

   task automatic run(logic [4:0] b, logic e, int n);
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         bin = b;
         en  = e;
         cycle();
      end
   endtask

   initial begin
      m_reset();
      cycle();
      cycle();
      check("reset", {lvl, prs, rel}, '0);
      @(negedge clk);
      rst = 1'b0;

      // clean press on channel 0
      tbl.push_back('{5'h01, 1'b1, 5,  5'h00, 5'h00, 5'h00});
      tbl.push_back('{5'h01, 1'b1, 1,  5'h01, 5'h01, 5'h00});
      tbl.push_back('{5'h01, 1'b1, 1,  5'h01, 5'h00, 5'h00});
      tbl.push_back('{5'h01, 1'b1, 13, 5'h01, 5'h00, 5'h00});
      tbl.push_back('{5'h00, 1'b1, 5,  5'h01, 5'h00, 5'h00});
      tbl.push_back('{5'h00, 1'b1, 1,  5'h00, 5'h00, 5'h01});
      tbl.push_back('{5'h00, 1'b1, 1,  5'h00, 5'h00, 5'h00});
      // bounce on channel 2, then a release landing on a repeat boundary
      tbl.push_back('{5'h04, 1'b1, 1,  5'h00, 5'h00, 5'h00});
      tbl.push_back('{5'h00, 1'b1, 2,  5'h00, 5'h00, 5'h00});
      tbl.push_back('{5'h04, 1'b1, 2,  5'h00, 5'h00, 5'h00});
      tbl.push_back('{5'h00, 1'b1, 2,  5'h00, 5'h00, 5'h00});
      tbl.push_back('{5'h04, 1'b1, 3,  5'h00, 5'h00, 5'h00});
      tbl.push_back('{5'h00, 1'b1, 2,  5'h00, 5'h00, 5'h00});
      tbl.push_back('{5'h04, 1'b1, 5,  5'h00, 5'h00, 5'h00});
      tbl.push_back('{5'h04, 1'b1, 1,  5'h04, 5'h04, 5'h00});
      tbl.push_back('{5'h04, 1'b1, 9,  5'h04, 5'h00, 5'h00});
      tbl.push_back('{5'h04, 1'b1, 1,  5'h04, 5'h04, 5'h00});
      tbl.push_back('{5'h00, 1'b1, 2,  5'h04, 5'h00, 5'h00});
      tbl.push_back('{5'h00, 1'b1, 1,  5'h04, 5'h04, 5'h00});
      tbl.push_back('{5'h00, 1'b1, 2,  5'h04, 5'h00, 5'h00});
      tbl.push_back('{5'h00, 1'b1, 1,  5'h00, 5'h00, 5'h04});
      tbl.push_back('{5'h00, 1'b1, 1,  5'h00, 5'h00, 5'h00});
      // enable gating on channel 3 and on repeat channel 1
      tbl.push_back('{5'h08, 1'b0, 5,  5'h00, 5'h00, 5'h00});
      tbl.push_back('{5'h08, 1'b0, 1,  5'h08, 5'h00, 5'h00});
      tbl.push_back('{5'h08, 1'b1, 5,  5'h08, 5'h00, 5'h00});
      tbl.push_back('{5'h00, 1'b1, 5,  5'h08, 5'h00, 5'h00});
      tbl.push_back('{5'h00, 1'b1, 1,  5'h00, 5'h00, 5'h08});
      tbl.push_back('{5'h00, 1'b1, 1,  5'h00, 5'h00, 5'h00});
      tbl.push_back('{5'h02, 1'b0, 6,  5'h02, 5'h00, 5'h00});
      tbl.push_back('{5'h02, 1'b1, 15, 5'h02, 5'h00, 5'h00});
      tbl.push_back('{5'h00, 1'b1, 5,  5'h02, 5'h00, 5'h00});
      tbl.push_back('{5'h00, 1'b1, 1,  5'h00, 5'h00, 5'h02});
      // all channels at once
      tbl.push_back('{5'h1f, 1'b1, 5,  5'h00, 5'h00, 5'h00});
      tbl.push_back('{5'h1f, 1'b1, 1,  5'h1f, 5'h1f, 5'h00});
      tbl.push_back('{5'h1f, 1'b1, 1,  5'h1f, 5'h00, 5'h00});
      tbl.push_back('{5'h00, 1'b1, 5,  5'h1f, 5'h00, 5'h00});
      tbl.push_back('{5'h00, 1'b1, 1,  5'h00, 5'h00, 5'h1f});
      tbl.push_back('{5'h00, 1'b1, 1,  5'h00, 5'h00, 5'h00});

      foreach (tbl[i]) begin
         run(tbl[i].b, tbl[i].e, tbl[i].n);
         check($sformatf("row%0d", i), {lvl, prs, rel}, {tbl[i].l, tbl[i].p, tbl[i].r});
      end

      // auto-repeat on channel 1, held 40 cycles past the press
      run(5'h02, 1'b1, 5);
      check("rpt_pre", {10'h0, prs}, '0);
      run(5'h02, 1'b1, 1);
      check("rpt_press", {10'h0, prs}, {10'h0, 5'h02});
      for (int k = 1; k <= 40; k++) begin
         run(5'h02, 1'b1, 1);
         check($sformatf("rpt_k%0d", k), {14'h0, prs[1]},
               {14'h0, k == RD || (k > RD && (k - RD) % RR == 0)});
      end
      run(5'h00, 1'b1, 5);
      run(5'h00, 1'b1, 1);
      check("rpt_release", {5'h0, prs, rel}, {5'h0, 5'h00, 5'h02});
      run(5'h00, 1'b1, 2);

      // reset while channel 1 is in the repeat phase
      run(5'h02, 1'b1, 6);
      check("mid_press", {10'h0, prs}, {10'h0, 5'h02});
      run(5'h02, 1'b1, 14);
      @(negedge clk);
      #2 rst = 1'b1;
      m_reset();
      #1 check("reset_async", {lvl, prs, rel}, '0);
      cycle();
      cycle();
      @(negedge clk);
      rst = 1'b0;
      repeat (5) cycle();
      check("rst_pre", {5'h0, lvl, prs}, '0);
      cycle();
      check("rst_press", {lvl, prs, rel}, {5'h02, 5'h02, 5'h00});
      repeat (9) cycle();
      check("rst_gap", {10'h0, prs}, '0);
      cycle();
      check("rst_rpt", {10'h0, prs}, {10'h0, 5'h02});
      run(5'h00, 1'b1, 8);

      for (int k = 0; k < 3000; k++) begin
         logic [4:0] b;
         b = bin;
         for (int c = 0; c < N; c++)
            if ($urandom_range(0, 99) < 6) b[c] = ~b[c];
         @(negedge clk);
         bin = b;
         if ($urandom_range(0, 99) < 3) en = ~en;
         rst = ($urandom_range(0, 499) == 0);
         if (rst) m_reset();
         cycle();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
